// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
// Shared definitions for the UART/ALU sequencer:
//   - 3-bit FSM state encoding used by uart_alu_ctrl
//   - ALU opcode constants (6-bit, MIPS funct style) for software and benches
package uart_alu_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_B   = 3'd1;
  localparam logic [2:0] ST_GET_OP  = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_ctrl_rise_edge_det.sv
// rise_edge_det
// Turns a pulse-or-level flag into a single-cycle event on its rising edge.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset (history cleared to 0)
//   level in  flag to watch
//   evt   out high for the cycle in which level is 1 and was 0 on the last edge
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic evt
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign evt = level & ~prev;

endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
// Sequencer between a UART tx/rx pair and a combinational ALU. Collects
// operand A, operand B and opcode bytes, latches the ALU result, launches a
// one-byte transmit and waits for its completion. Aborts on inter-byte
// timeout and flags bytes that arrive while busy.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_rx_data/i_rx_valid     received byte + flag (rising edge = new byte)
//   o_tx_data/o_tx_start     result byte + one-cycle tx request
//   i_tx_done                tx-sent flag (rising edge = byte sent)
//   o_alu_a/o_alu_b/o_alu_op registered ALU operands
//   i_alu_result             combinational ALU result
//   o_busy                   high whenever the FSM is not idle
//   o_err_timeout/o_err_overrun sticky error flags, cleared by a new operand A
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int PAYLOAD_SIZE   = 8,
  parameter int OP_SIZE        = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PAYLOAD_SIZE-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic [PAYLOAD_SIZE-1:0] o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic [PAYLOAD_SIZE-1:0] o_alu_a,
  output logic [PAYLOAD_SIZE-1:0] o_alu_b,
  output logic [OP_SIZE-1:0]      o_alu_op,
  input  logic [PAYLOAD_SIZE-1:0] i_alu_result,
  output logic                    o_busy,
  output logic                    o_err_timeout,
  output logic                    o_err_overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rx_evt;
  logic             tx_evt;

  // Opcode byte bits above OP_SIZE are deliberately ignored.
  logic unused_rx_hi;
  assign unused_rx_hi = ^i_rx_data;

  rise_edge_det u_rx_edge (
    .clk   (i_clk),
    .rst_n (i_rst),
    .level (i_rx_valid),
    .evt   (rx_evt)
  );

  rise_edge_det u_tx_edge (
    .clk   (i_clk),
    .rst_n (i_rst),
    .level (i_tx_done),
    .evt   (tx_evt)
  );

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_op      <= '0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      // Only EXEC raises tx_start, so this default makes it a 1-cycle pulse.
      o_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_evt) begin
            o_alu_a       <= i_rx_data;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;
            cnt           <= '0;
            state         <= ST_GET_B;
          end
        end
        ST_GET_B, ST_GET_OP: begin
          // A byte arriving on the expiry edge takes priority over timeout.
          if (rx_evt) begin
            cnt <= '0;
            if (state == ST_GET_B) begin
              o_alu_b <= i_rx_data;
              state   <= ST_GET_OP;
            end else begin
              o_alu_op <= i_rx_data[OP_SIZE-1:0];
              state    <= ST_EXEC;
            end
          end else if (cnt == CNT_LAST) begin
            o_err_timeout <= 1'b1;
            cnt           <= '0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          if (rx_evt) o_err_overrun <= 1'b1;
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (rx_evt) o_err_overrun <= 1'b1;
          if (tx_evt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between the UART datapath (tx/rx pair with per-byte flags) and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them onto the ALU and captures the result.
- Launches a one-byte UART transmit of the result and waits for tx completion before accepting the next transaction.
- Enforces an inter-byte timeout and flags bytes dropped while busy.

Parameters:
PAYLOAD_SIZE, 8, width of UART byte, operands and result
OP_SIZE, 6, width of ALU opcode (low OP_SIZE bits of the opcode byte)
TIMEOUT_CYCLES, 1000000, clock edges without a byte in GET_B/GET_OP before abort (>=2)

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  reset, asynchronous, active-low (0 = reset)
i_rx_data  in  PAYLOAD_SIZE  received byte from UART rx
i_rx_valid  in  1  UART rx data-received flag; pulse or level, rising edge = new byte
o_tx_data  out  PAYLOAD_SIZE  byte to transmit (registered ALU result)
o_tx_start  out  1  one-cycle pulse requesting UART tx
i_tx_done  in  1  UART tx data-sent flag; rising edge = byte sent
o_alu_a  out  PAYLOAD_SIZE  registered operand A
o_alu_b  out  PAYLOAD_SIZE  registered operand B
o_alu_op  out  OP_SIZE  registered opcode
i_alu_result  in  PAYLOAD_SIZE  combinational ALU result
o_busy  out  1  high whenever state != IDLE
o_err_timeout  out  1  sticky inter-byte timeout flag
o_err_overrun  out  1  sticky dropped-byte flag

Behaviour:
- Reset (i_rst=0, async): state=IDLE. All outputs 0. Timeout counter 0. Edge-detect history regs 0.
- Edge detect: rx_evt = i_rx_valid & ~rx_prev, with rx_prev registered each edge. tx_evt is formed identically from i_tx_done. A level held N cycles counts as one event.
- FSM, states IDLE, GET_B, GET_OP, EXEC, WAIT_TX:
  - IDLE: on rx_evt, o_alu_a<=i_rx_data, clear both error flags, go to GET_B.
  - GET_B: on rx_evt, o_alu_b<=i_rx_data, go to GET_OP.
  - GET_OP: on rx_evt, o_alu_op<=i_rx_data[OP_SIZE-1:0], go to EXEC.
  - EXEC (exactly 1 cycle): o_tx_data<=i_alu_result, o_tx_start<=1, go to WAIT_TX.
  - WAIT_TX: o_tx_start<=0 on the first edge. On tx_evt, go to IDLE.
- Latency: opcode captured at edge k. Result latched at k+1. o_tx_start high from k+1 to k+2, exactly one cycle. Earliest return to IDLE is the edge that sees tx_evt.
- Timeout:
  - Counter cleared on entry to GET_B and on every accepted byte.
  - Increments each edge in GET_B and GET_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_evt: go to IDLE, set o_err_timeout, leave o_alu_* unchanged.
  - If rx_evt coincides with expiry, the byte wins and there is no timeout.
- Overrun: an rx_evt in EXEC or WAIT_TX is dropped and sets o_err_overrun. The state does not change.
- tx_evt outside WAIT_TX is ignored.
- tx_evt in the same cycle as o_tx_start is not accepted, since the state is still EXEC at that edge.
- o_alu_a/b/op hold their last captured value until overwritten. They are stable throughout EXEC and WAIT_TX.
- Error flags are cleared only by reset or by acceptance of a new operand A.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A pending tx is abandoned, and the UART side completes on its own.

Decomposition:
- Shared package uart_alu_pkg holds:
  - State encoding localparams (3-bit: IDLE=0, GET_B=1, GET_OP=2, EXEC=3, WAIT_TX=4).
  - ALU opcode constants: ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, NOR=6'b100111, SRA=6'b000011, SRL=6'b000010.
- The controller passes the opcode through without validating it.
- One sub-module: rise_edge_det (1-bit, async active-low reset), instantiated twice, for rx and tx flags.
- Timeout counter width = $clog2(TIMEOUT_CYCLES).

Test Plan:
- Basic transaction: rx bytes 0x05, 0x03, 0x20; ALU model returns 0x08 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08; o_tx_start high for exactly 1 cycle, 1 cycle after opcode capture; o_busy high until tx_done pulse, then 0.
- Timeout, TIMEOUT_CYCLES=16: send 0xAA, then idle for 16 cycles -> IDLE and o_err_timeout=1. Next byte 0x11 -> o_err_timeout=0 and o_alu_a=0x11. Byte arriving on edge 15 is accepted with no timeout.
- Overrun: full transaction; inject rx byte 0x77 while in WAIT_TX -> o_err_overrun=1, state stays WAIT_TX, o_alu_* unchanged. After tx_done, the next A byte clears the flag.
- Level flags: i_rx_valid held high 5 cycles with data 0x42 -> only o_alu_a captured, state GET_B, not GET_OP. A stray i_tx_done in IDLE -> no state change.
- Reset mid-WAIT_TX: assert i_rst=0 asynchronously between clock edges -> all outputs 0 immediately, without waiting for a clock edge. After release, a new 0x01/0x02/0x22 transaction completes normally.
- Back-to-back: two transactions with the next A byte arriving on the same edge as tx_evt. The byte is dropped as overrun, because the state is still WAIT_TX on that edge. Verify o_err_overrun=1 and the controller is ready on the next rx_evt.
